ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_host_tx.sv | 168 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM encoding, frame length
// and default timing parameters (cycles of a 12 MHz system clock).
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_RELEASE,
    ST_DONE
  } ps2State_e;

  // start + 8 data + parity + stop; the device's ack rides on an 11th clock
  localparam int FRAME_BITS      = 11;
  localparam int INHIBIT_CYC_DEF = 1200;
  localparam int TIMEOUT_CYC_DEF = 24000;

  function automatic int cntWidth(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus a falling-edge detector
// that fires for one cycle when the synchronised level goes 1 -> 0.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: pops a command byte, inhibits the bus,
// requests to send, shifts out data/parity/stop on device clocks, checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = INHIBIT_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        VPWR,
  inout  wire        VGND,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int         CNT_W    = cntWidth(INHIBIT_CYC, TIMEOUT_CYC);
  // bit counter value seen on the 10th (stop) edge
  localparam logic [3:0] STOP_CNT = 4'(FRAME_BITS - 2);

  ps2State_e        state_q, state_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bitCnt_q, bitCnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             dataOe_q, dataOe_d;
  logic             ackOk_q, ackOk_d;
  logic             err_q, err_d;

  logic clkLvl, clkFall, dataLvl;
  logic unusedDataFall;
  logic unusedRails;
  logic inFrame, timedOut;

  assign unusedRails = VPWR ^ VGND;

  ps2_line_sync u_clkSync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .line_i (ps2_clk_in),
    .level_o(clkLvl),
    .fall_o (clkFall)
  );

  ps2_line_sync u_dataSync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .line_i (ps2_data_in),
    .level_o(dataLvl),
    .fall_o (unusedDataFall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      cyc_q    <= '0;
      dataOe_q <= 1'b0;
      ackOk_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      cyc_q    <= cyc_d;
      dataOe_q <= dataOe_d;
      ackOk_q  <= ackOk_d;
      err_q    <= err_d;
    end
  end

  assign inFrame  = (state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_RELEASE);
  assign timedOut = (cyc_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    cyc_d    = cyc_q;
    dataOe_d = dataOe_q;
    ackOk_d  = ackOk_q;
    err_d    = err_q;

    // cyc_q counts cycles since REQ, so DONE lands exactly TIMEOUT_CYC after it
    if (inFrame && timedOut) begin
      dataOe_d = 1'b0;
      ackOk_d  = 1'b0;
      err_d    = 1'b1;
      state_d  = ST_DONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_d = ST_POP;
        end
        ST_POP: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          shift_d = {~^fifo_data, fifo_data};
          ackOk_d = 1'b0;
          err_d   = 1'b0;
          cyc_d   = '0;
          state_d = ST_INHIBIT;
        end
        ST_INHIBIT: begin
          if (cyc_q == CNT_W'(INHIBIT_CYC - 1)) state_d = ST_REQ;
          else                                  cyc_d   = cyc_q + CNT_W'(1);
        end
        ST_REQ: begin
          bitCnt_d = '0;
          cyc_d    = CNT_W'(1);
          dataOe_d = 1'b1;
          state_d  = ST_SHIFT;
        end
        ST_SHIFT: begin
          cyc_d = cyc_q + CNT_W'(1);
          if (clkFall) begin
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == STOP_CNT) begin
              dataOe_d = 1'b0;
              state_d  = ST_ACK;
            end else begin
              dataOe_d = ~shift_q[0];
              shift_d  = shift_q >> 1;
            end
          end
        end
        ST_ACK: begin
          cyc_d = cyc_q + CNT_W'(1);
          if (clkFall) begin
            ackOk_d = ~dataLvl;
            err_d   = dataLvl;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          cyc_d = cyc_q + CNT_W'(1);
          if (clkLvl && dataLvl) state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // line drives decode straight from state so reset releases the bus at once
  assign ps2_clk_oe  = (state_q == ST_INHIBIT);
  assign ps2_data_oe = (state_q == ST_REQ) || ((state_q == ST_SHIFT) && dataOe_q);
  assign fifo_rd_en  = (state_q == ST_POP);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign ack_ok      = ackOk_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a FIFO model and PS/2 device model drive the
// DUT, expected frame results are queued per command and checked on every done.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 600;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wire vpwr;
  wire vgnd;
  assign vpwr = 1'b1;
  assign vgnd = 1'b0;

  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_ok, err;

  logic devClkLow  = 1'b0;
  logic devDataLow = 1'b0;
  logic ps2ClkLine, ps2DataLine;
  assign ps2ClkLine  = ~(ps2_clk_oe | devClkLow);
  assign ps2DataLine = ~(ps2_data_oe | devDataLow);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .VPWR       (vpwr),
    .VGND       (vgnd),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .ps2_clk_in (ps2ClkLine),
    .ps2_data_in(ps2DataLine),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .err        (err)
  );

  // command FIFO model with registered read data
  logic [7:0] fifoMem [0:15];
  int wrPtr = 0;
  int rdPtr = 0;
  assign fifo_empty = (wrPtr == rdPtr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= fifoMem[rdPtr[3:0]];
      rdPtr     <= rdPtr + 1;
    end
  end

  typedef struct {
    logic [10:0] frame;
    bit          checkFrame;
    logic        ackOk;
    logic        err;
    int          latency;
  } exp_t;

  exp_t expQ[$];
  int checks   = 0;
  int failures = 0;
  int expPops  = 0;
  int popCount = 0;
  int cycle    = 0;
  int reqCycle = 0;
  logic [10:0] capFrame = '0;
  int devEdge = 0;
  bit devActive = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cycle);
    end
  endtask

  task automatic pushFifo(input logic [7:0] b);
    fifoMem[wrPtr[3:0]] = b;
    wrPtr = wrPtr + 1;
  endtask

  // queue one command: start 0, data LSB first, hand-computed parity, stop 1
  task automatic queueFrame(input logic [7:0] data, input logic parity, input bit ackLow);
    exp_t e;
    e.frame      = {1'b1, parity, data, 1'b0};
    e.checkFrame = 1'b1;
    e.ackOk      = ackLow;
    e.err        = ~ackLow;
    e.latency    = 0;
    expQ.push_back(e);
    expPops++;
    pushFifo(data);
  endtask

  // PS/2 device: waits for inhibit + request, then clocks nEdges pulses
  task automatic deviceFrame(input int nEdges, input bit ackLow);
    int n;
    bit seen;
    devActive = 1'b1;
    devEdge   = 0;
    capFrame  = '0;
    seen      = 1'b0;
    n         = 0;
    while (n < 400 && !(seen && !ps2_clk_oe && !ps2DataLine)) begin
      @(negedge clk);
      if (ps2_clk_oe) seen = 1'b1;
      n++;
    end
    if (n >= 400) begin
      checkInt("devReqWait", n, 0);
    end else begin
      repeat (4) @(negedge clk);
      capFrame[0] = ps2DataLine;
      for (int i = 1; i <= nEdges; i++) begin
        devClkLow = 1'b1;
        devEdge   = i;
        repeat (HALF) @(negedge clk);
        if (i <= 10) capFrame[i] = ps2DataLine;
        devClkLow = 1'b0;
        if (i == 10) devDataLow = ackLow;
        if (i == 11) devDataLow = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
    devClkLow  = 1'b0;
    devDataLow = 1'b0;
    devActive  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic parity, input bit ackLow);
    queueFrame(data, parity, ackLow);
    deviceFrame(11, ackLow);
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() > 0) begin
      checkInt("drainTimeout", expQ.size(), 0);
      expQ.delete();
    end
  endtask

  // monitor: inhibit width, REQ timestamp, pop pulses, and scoreboard on done
  int   inhRun = 0;
  logic prevClkOe = 1'b0, prevDataOe = 1'b0, prevRdEn = 1'b0;
  exp_t mon;
  always @(negedge clk) begin
    if (!rst_n) begin
      inhRun     = 0;
      prevClkOe  = 1'b0;
      prevDataOe = 1'b0;
      prevRdEn   = 1'b0;
    end else begin
      if (ps2_clk_oe) inhRun++;
      else if (inhRun > 0) begin
        checkInt("inhibitLen", inhRun, INH);
        inhRun = 0;
      end
      if (ps2_data_oe && !prevDataOe && prevClkOe) reqCycle = cycle;
      if (fifo_rd_en) begin
        popCount++;
        checkBit("popWidth", prevRdEn, 1'b0);
      end
      if (done) begin
        if (expQ.size() == 0) begin
          checkBit("unexpectedDone", done, 1'b0);
        end else begin
          mon = expQ.pop_front();
          checkBit("doneAckOk", ack_ok, mon.ackOk);
          checkBit("doneErr", err, mon.err);
          checkBit("doneClkOe", ps2_clk_oe, 1'b0);
          checkBit("doneDataOe", ps2_data_oe, 1'b0);
          if (mon.checkFrame) checkInt("frameBits", int'(capFrame), int'(mon.frame));
          if (mon.latency > 0) checkInt("timeoutLatency", cycle - reqCycle, mon.latency);
        end
      end
      prevClkOe  = ps2_clk_oe;
      prevDataOe = ps2_data_oe;
      prevRdEn   = fifo_rd_en;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int basePops;
    int n;
    exp_t e;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkBit("rstBusy", busy, 1'b0);
    checkBit("rstDone", done, 1'b0);
    checkBit("rstRdEn", fifo_rd_en, 1'b0);
    checkBit("rstClkOe", ps2_clk_oe, 1'b0);
    checkBit("rstDataOe", ps2_data_oe, 1'b0);
    checkBit("rstAckOk", ack_ok, 1'b0);
    checkBit("rstErr", err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED: bits 1,0,1,1,0,1,1,1 with parity 1, acknowledged
    applyStimulus(8'hED, 1'b1, 1'b1);
    waitDrain(100);
    repeat (5) @(negedge clk);
    checkBit("holdAckOk", ack_ok, 1'b1);
    checkBit("holdErr", err, 1'b0);
    checkBit("idleBusy", busy, 1'b0);

    applyStimulus(8'h01, 1'b0, 1'b1);
    waitDrain(100);
    applyStimulus(8'hFF, 1'b1, 1'b1);
    waitDrain(100);

    // no acknowledge: 0x3C has four ones, parity 1
    applyStimulus(8'h3C, 1'b1, 1'b0);
    waitDrain(100);
    repeat (5) @(negedge clk);
    checkBit("holdNackErr", err, 1'b1);
    checkBit("holdNackAck", ack_ok, 1'b0);

    // device never clocks
    e.frame = '0; e.checkFrame = 1'b0; e.ackOk = 1'b0; e.err = 1'b1; e.latency = TO;
    expQ.push_back(e);
    expPops++;
    pushFifo(8'h55);
    waitDrain(TO + INH + 50);
    repeat (5) @(negedge clk);

    // reset in the middle of data bit 3 (0xA5 bit 3 = 0, so data is pulled low)
    pushFifo(8'hA5);
    expPops++;
    fork
      deviceFrame(4, 1'b1);
    join_none
    n = 0;
    while (devEdge != 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkInt("reachEdge4", devEdge, 4);
    repeat (5) @(negedge clk);
    checkBit("bit3DataOe", ps2_data_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkBit("midRstClkOe", ps2_clk_oe, 1'b0);
    checkBit("midRstDataOe", ps2_data_oe, 1'b0);
    checkBit("midRstBusy", busy, 1'b0);
    n = 0;
    while (devActive && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    basePops = popCount;
    repeat (30) @(negedge clk);
    checkInt("noPopAfterReset", popCount - basePops, 0);
    checkBit("idleAfterReset", busy, 1'b0);

    // back-to-back commands: 0xF4 (parity 0), 0xF5 (parity 1)
    basePops = popCount;
    queueFrame(8'hF4, 1'b0, 1'b1);
    queueFrame(8'hF5, 1'b1, 1'b1);
    deviceFrame(11, 1'b1);
    deviceFrame(11, 1'b1);
    waitDrain(100);
    repeat (10) @(negedge clk);
    checkInt("b2bPops", popCount - basePops, 2);

    checkInt("totalPops", popCount, expPops);
    checkInt("scoreboardLeft", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
